// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the execute-stage ALU: operation codes,
// FSM states and the JAL link offset.
package alu_exec_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_BEQ  = 4'b1000,
    OP_BLT  = 4'b1001,
    OP_BGE  = 4'b1010,
    OP_BNE  = 4'b1011,
    OP_SLT  = 4'b1100,
    OP_JAL  = 4'b1101,
    OP_LUI  = 4'b1110,
    OP_RSVD = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } exec_state_t;

  localparam int JAL_OFFSET = 4;

  function automatic logic is_shift(input alu_op_t op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle result and branch evaluation for every non-iterative code.
// Shift codes pass SrcA through so a zero-amount shift finishes in one cycle.
module alu_comb_core
  import alu_exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  branch_taken
);

  logic [DATA_WIDTH-1:0] diff;
  logic                  lt_signed;
  alu_op_t               op;

  assign op        = alu_op_t'(Operation);
  assign diff      = SrcA - SrcB;
  assign lt_signed = $signed(SrcA) < $signed(SrcB);

  // Branch codes report the difference as their result; only they raise branch_taken.
  always_comb begin
    result       = '0;
    branch_taken = 1'b0;
    unique case (op)
      OP_AND:  result = SrcA & SrcB;
      OP_OR:   result = SrcA | SrcB;
      OP_ADD:  result = SrcA + SrcB;
      OP_XOR:  result = SrcA ^ SrcB;
      OP_SUB:  result = diff;
      OP_SRL,
      OP_SLL,
      OP_SRA:  result = SrcA;
      OP_BEQ: begin
        result       = diff;
        branch_taken = (SrcA == SrcB);
      end
      OP_BLT: begin
        result       = diff;
        branch_taken = lt_signed;
      end
      OP_BGE: begin
        result       = diff;
        branch_taken = !lt_signed;
      end
      OP_BNE: begin
        result       = diff;
        branch_taken = (SrcA != SrcB);
      end
      OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
      OP_JAL:  result = SrcA + DATA_WIDTH'(JAL_OFFSET);
      OP_LUI:  result = SrcB;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle EX-stage ALU with valid/ready handshakes; shifts iterate one
// bit per cycle, everything else completes through alu_comb_core in one cycle.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  BranchTaken
);

  exec_state_t           state;
  alu_op_t               shift_op;
  logic [SHAMT_W-1:0]    count;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] core_result;
  logic                  core_branch;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  accept;
  logic                  start_shift;

  alu_comb_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .Operation    (Operation),
    .SrcA         (SrcA),
    .SrcB         (SrcB),
    .result       (core_result),
    .branch_taken (core_branch)
  );

  assign shamt       = SrcB[SHAMT_W-1:0];
  assign in_ready    = ((state == IDLE) || ((state == DONE) && out_ready)) && !flush;
  assign accept      = in_valid && in_ready;
  assign start_shift = is_shift(alu_op_t'(Operation)) && (shamt != '0);

  // One-bit step of the in-flight shift, applied to the result register itself.
  always_comb begin
    shifted = ALUResult;
    case (shift_op)
      OP_SRL:  shifted = {1'b0, ALUResult[DATA_WIDTH-1:1]};
      OP_SLL:  shifted = {ALUResult[DATA_WIDTH-2:0], 1'b0};
      OP_SRA:  shifted = {ALUResult[DATA_WIDTH-1], ALUResult[DATA_WIDTH-1:1]};
      default: shifted = ALUResult;
    endcase
  end

  // accept is only possible from IDLE or a draining DONE, so it is handled first
  // and covers the back-to-back case; flush outranks everything except reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_op    <= OP_AND;
      count       <= '0;
      ALUResult   <= '0;
      Zero        <= 1'b1;
      BranchTaken <= 1'b0;
      out_valid   <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else if (accept) begin
      if (start_shift) begin
        state       <= SHIFT;
        shift_op    <= alu_op_t'(Operation);
        count       <= shamt;
        ALUResult   <= SrcA;
        BranchTaken <= 1'b0;
        out_valid   <= 1'b0;
      end else begin
        state       <= DONE;
        ALUResult   <= core_result;
        Zero        <= (core_result == '0);
        BranchTaken <= core_branch;
        out_valid   <= 1'b1;
      end
    end else begin
      case (state)
        SHIFT: begin
          ALUResult <= shifted;
          count     <= count - 1'b1;
          if (count == SHAMT_W'(1)) begin
            state     <= DONE;
            Zero      <= (shifted == '0);
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: one task per scenario,
// expected values computed by hand from the operation definitions.
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        BranchTaken;

  int nCompared   = 0;
  int nMismatched = 0;

  alu_exec_unit #(
    .DATA_WIDTH (32),
    .SHAMT_W    (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Operation   (Operation),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALUResult   (ALUResult),
    .Zero        (Zero),
    .BranchTaken (BranchTaken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op and let the accept edge happen, then drop in_valid.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    nCompared++;
    if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    nCompared++;
    if (ALUResult !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_result: got %h expected 00000000", ALUResult); end
    nCompared++;
    if (Zero !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_zero: got %b expected 1", Zero); end
    nCompared++;
    if (BranchTaken !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_branch: got %b expected 0", BranchTaken); end
    reset = 1'b0;
    tick();
    nCompared++;
    if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    issue(OP_ADD, 32'd5, 32'd7);
    nCompared++;
    if (out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL add_valid: got %b expected 1", out_valid); end
    nCompared++;
    if (ALUResult !== 32'd12) begin nMismatched++; $display("[TB] FAIL add_result: got %h expected 0000000c", ALUResult); end
    nCompared++;
    if (Zero !== 1'b0 || BranchTaken !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL add_flags: got Zero=%b BT=%b expected 0 0", Zero, BranchTaken);
    end
    tick();
    nCompared++;
    if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_sra();
    out_ready = 1'b1;
    issue(OP_SRA, 32'h8000_0000, 32'd4);
    // Operands may change freely while shifting.
    SrcA = 32'h1234_5678;
    SrcB = 32'h0000_0001;
    Operation = OP_ADD;
    for (int i = 0; i < 4; i++) begin
      nCompared++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL sra_busy_%0d: got in_ready=%b out_valid=%b expected 0 0", i, in_ready, out_valid);
      end
      tick();
    end
    nCompared++;
    if (out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL sra_valid: got %b expected 1", out_valid); end
    nCompared++;
    if (ALUResult !== 32'hF800_0000) begin nMismatched++; $display("[TB] FAIL sra_result: got %h expected f8000000", ALUResult); end
    tick();
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    issue(OP_BLT, 32'hFFFF_FFFF, 32'd1);
    nCompared++;
    if (BranchTaken !== 1'b1 || ALUResult !== 32'hFFFF_FFFE) begin
      nMismatched++; $display("[TB] FAIL blt: got BT=%b res=%h expected 1 fffffffe", BranchTaken, ALUResult);
    end
    tick();
    issue(OP_BGE, 32'hFFFF_FFFF, 32'd1);
    nCompared++;
    if (BranchTaken !== 1'b0) begin nMismatched++; $display("[TB] FAIL bge: got %b expected 0", BranchTaken); end
    tick();
    issue(OP_BEQ, 32'd9, 32'd9);
    nCompared++;
    if (BranchTaken !== 1'b1 || Zero !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL beq: got BT=%b Zero=%b expected 1 1", BranchTaken, Zero);
    end
    tick();
    issue(OP_BNE, 32'd9, 32'd9);
    nCompared++;
    if (BranchTaken !== 1'b0) begin nMismatched++; $display("[TB] FAIL bne: got %b expected 0", BranchTaken); end
    tick();
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1);
    nCompared++;
    if (ALUResult !== 32'd1 || BranchTaken !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL slt: got res=%h BT=%b expected 00000001 0", ALUResult, BranchTaken);
    end
    tick();
    issue(OP_JAL, 32'd100, 32'd0);
    nCompared++;
    if (ALUResult !== 32'd104) begin nMismatched++; $display("[TB] FAIL jal: got %h expected 00000068", ALUResult); end
    tick();
    issue(OP_LUI, 32'd3, 32'hABCD_E000);
    nCompared++;
    if (ALUResult !== 32'hABCD_E000) begin nMismatched++; $display("[TB] FAIL lui: got %h expected abcde000", ALUResult); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    issue(OP_XOR, 32'h0000_00F0, 32'h0000_00FF);
    for (int i = 0; i < 4; i++) begin
      nCompared++;
      if (out_valid !== 1'b1 || ALUResult !== 32'h0000_000F) begin
        nMismatched++;
        $display("[TB] FAIL xor_hold_%0d: got valid=%b res=%h expected 1 0000000f", i, out_valid, ALUResult);
      end
      if (i < 3) tick();
    end
    out_ready = 1'b1;
    Operation = OP_SUB;
    SrcA      = 32'd3;
    SrcB      = 32'd5;
    in_valid  = 1'b1;
    #1;
    nCompared++;
    if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_in_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    nCompared++;
    if (out_valid !== 1'b1 || ALUResult !== 32'hFFFF_FFFE) begin
      nMismatched++; $display("[TB] FAIL b2b_sub: got valid=%b res=%h expected 1 fffffffe", out_valid, ALUResult);
    end
    tick();
  endtask

  task automatic test_flush_and_reset();
    bit sawValid;
    out_ready = 1'b1;
    issue(OP_SRL, 32'hFFFF_FFFF, 32'd31);
    tick();
    tick();
    flush = 1'b1;
    #1;
    nCompared++;
    if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_in_ready_busy: got %b expected 0", in_ready); end
    tick();
    flush = 1'b0;
    #1;
    nCompared++;
    if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL flush_in_ready: got %b expected 1", in_ready); end
    nCompared++;
    if (ALUResult !== 32'h3FFF_FFFF) begin nMismatched++; $display("[TB] FAIL flush_result_kept: got %h expected 3fffffff", ALUResult); end
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) sawValid = 1'b1;
      tick();
    end
    nCompared++;
    if (sawValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_no_valid: got %b expected 0", sawValid); end

    issue(OP_SRL, 32'hFFFF_FFFF, 32'd31);
    tick();
    tick();
    reset = 1'b1;
    #1;
    nCompared++;
    if (out_valid !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b1 || BranchTaken !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midreset: got valid=%b res=%h Zero=%b BT=%b expected 0 00000000 1 0",
               out_valid, ALUResult, Zero, BranchTaken);
    end
    tick();
    reset = 1'b0;
    tick();
    nCompared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL midreset_idle: got in_ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_edge_codes();
    out_ready = 1'b1;
    issue(OP_RSVD, 32'd5, 32'd6);
    nCompared++;
    if (out_valid !== 1'b1 || ALUResult !== 32'h0 || BranchTaken !== 1'b0 || Zero !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL reserved: got valid=%b res=%h BT=%b Zero=%b expected 1 00000000 0 1",
               out_valid, ALUResult, BranchTaken, Zero);
    end
    tick();
    issue(OP_SLL, 32'd1, 32'h0000_0020);
    nCompared++;
    if (out_valid !== 1'b1 || ALUResult !== 32'd1) begin
      nMismatched++; $display("[TB] FAIL sll_zero_amt: got valid=%b res=%h expected 1 00000001", out_valid, ALUResult);
    end
    tick();
    issue(OP_SLL, 32'd1, 32'd1);
    nCompared++;
    if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL sll1_busy: got %b expected 0", out_valid); end
    tick();
    nCompared++;
    if (out_valid !== 1'b1 || ALUResult !== 32'd2) begin
      nMismatched++; $display("[TB] FAIL sll1: got valid=%b res=%h expected 1 00000002", out_valid, ALUResult);
    end
    tick();
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    Operation = 4'h0;
    SrcA      = '0;
    SrcB      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_add();
    test_sra();
    test_branch();
    test_back_to_back();
    test_flush_and_reset();
    test_edge_codes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute-stage ALU: the consumer of the 4-bit `Operation` code that the ALU controller decodes from ALUOp/Funct3/Funct7. It performs the operation selected by that code on two operands and returns the result and branch decision through valid/ready handshakes. Shifts run iteratively, one bit per cycle, to save area. Every other operation completes in one cycle. The block sits in the EX stage between the ID/EX pipeline register and the EX/MEM register and accepts a flush from the hazard unit.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.
- `SHAMT_W`, default 5: shift-amount width, equal to log2(DATA_WIDTH).

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  unit can accept this cycle.
- `Operation`  in  4  operation code (encoding below).
- `SrcA`  in  DATA_WIDTH  operand A.
- `SrcB`  in  DATA_WIDTH  operand B; SrcB[SHAMT_W-1:0] is the shift amount.
- `flush`  in  1  kill any in-flight operation.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream consumes the result.
- `ALUResult`  out  DATA_WIDTH  registered result.
- `Zero`  out  1  ALUResult == 0.
- `BranchTaken`  out  1  branch condition true (branch codes only).

## Operation
- Encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR.
  - 0100 SUB, 0101 SRL, 0110 SLL, 0111 SRA.
  - 1000 BEQ, 1001 BLT (signed), 1010 BGE (signed), 1011 BNE.
  - 1100 SLT (signed, result 0/1), 1101 JAL (result SrcA+4), 1110 LUI (result SrcB), 1111 reserved (result 0, BranchTaken 0).
- Branch codes: ALUResult = SrcA−SrcB; BranchTaken = condition. All other codes: BranchTaken = 0.
- Arithmetic wraps modulo 2^DATA_WIDTH. Carry and overflow are discarded.
- States are IDLE, SHIFT and DONE. Reset enters IDLE.
- Accept: `in_valid && in_ready` at a rising edge. Operands are latched.
  - Non-shift code, or shift with amount 0: go to DONE. Result is computed combinationally and registered.
  - Shift with amount n>0: go to SHIFT, count=n, ALUResult=SrcA.
- SHIFT: each cycle shift ALUResult by 1 (SRL fills 0, SLL fills 0, SRA replicates the MSB) and decrement count. When count==1 at the edge, go to DONE.
- DONE: out_valid=1. ALUResult, Zero and BranchTaken hold stable until `out_ready`.
  - `out_ready` without a new accept: go to IDLE.
  - `out_ready` with a new accept: back-to-back transfer; take the new op's path directly.
- in_ready = (state==IDLE) || (state==DONE && out_ready) && !flush.
- flush: at the next edge go to IDLE and clear out_valid. flush has priority over accept, shift and out_ready in the same cycle. ALUResult is not cleared.
- Reset mid-operation: the in-flight op is abandoned with no output.

## Timing
- Reset values:
  - out_valid=0, ALUResult=0, Zero=1, BranchTaken=0.
  - in_ready=1 once reset is deasserted (IDLE).
- Latency from the accept edge to out_valid high:
  - Non-shift, or shift amount 0: 1 cycle.
  - Shift amount n: n+1 cycles (max 32 for n=31).
- Throughput:
  - One op per cycle for non-shift ops when out_ready is held high.
  - Shifts block new accepts while in SHIFT.
- Zero and BranchTaken are registered alongside ALUResult. They are valid exactly while out_valid is high.
- Inputs are sampled only on the accept edge. SrcA, SrcB and Operation may change during SHIFT.

## Structure
- Package `alu_exec_pkg`:
  - `alu_op_t` enum holding the 16 codes.
  - `exec_state_t` enum (IDLE, SHIFT, DONE).
  - Localparam `JAL_OFFSET` = 4.
- One sub-module, `alu_comb_core`: combinational single-cycle result and branch evaluation for all non-shift codes. The top level holds the FSM, the shift datapath and the registers.

## Test plan
- Reset, then ADD SrcA=5, SrcB=7 with out_ready=1 → one cycle later out_valid=1, ALUResult=12, Zero=0, BranchTaken=0.
- SRA SrcA=0x80000000, SrcB=4 → in_ready=0 for 4 cycles; out_valid after 5 cycles with ALUResult=0xF8000000.
- BLT SrcA=0xFFFFFFFF, SrcB=1 → BranchTaken=1. BGE with the same operands → BranchTaken=0. BEQ 9,9 → BranchTaken=1, Zero=1.
- XOR 0xF0,0xFF with out_ready held low for 3 cycles → out_valid and ALUResult=0x0F stable for 4 cycles. A back-to-back SUB 3−5 accepted on the release edge yields 0xFFFFFFFE next cycle.
- SRL shamt 31, flush asserted in the 3rd SHIFT cycle → out_valid never rises and in_ready=1 the next cycle. Repeat the same op with reset asserted mid-shift → all outputs return to their reset values immediately.
- Code 1111 → ALUResult=0, BranchTaken=0, latency 1. SLL SrcA=1, SrcB=0x20 (shamt 0) → ALUResult=1, latency 1.
